seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand/op presented this cycle.
REQ-005 Port: in_ready  output  1  block accepts operation this cycle.
REQ-006 Port: a, b  input  WIDTH each  operands.
REQ-007 Port: alu_control  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SLT (signed), 110 SLTU, 111 MUL.
REQ-008 Port: out_valid  output  1  result/flags registers hold an unconsumed result.
REQ-009 Port: out_ready  input  1  consumer takes result this cycle.
REQ-010 Port: result  output  WIDTH  registered result.
REQ-011 Port: overflow, carry, zero  output  1 each  registered flags.
REQ-012 Port: busy  output  1  high while a MUL is iterating.

Function
REQ-013 Accept = in_valid & in_ready; a, b, alu_control captured only on accept.
REQ-014 in_ready = (state==IDLE) & (!out_valid | out_ready); back-to-back single-cycle ops at full rate when out_ready held high.
REQ-015 States: IDLE, MUL; IDLE->MUL on accepted MUL; MUL->IDLE after WIDTH iterations; no other transitions.
REQ-016 Non-MUL ops: result/flags registered the cycle after accept (latency 1), out_valid set same edge.
REQ-017 ADD: WIDTH-bit sum; carry = bit WIDTH of unsigned sum; overflow = signed overflow (same-sign operands, differing result sign).
REQ-018 SUB: a + ~b + 1; carry = carry-out (1 = no borrow); overflow = signed overflow (operand signs differ, result sign differs from a).
REQ-019 AND/XOR/OR: bitwise; overflow=0, carry=0.
REQ-020 SLT: result = zero-extended 1 if signed a<b, else 0; correct even when a-b overflows; overflow=0, carry=0.
REQ-021 SLTU: result = 1 if unsigned a<b, else 0; overflow=0, carry=0.
REQ-022 MUL: unsigned shift-add, one partial product per cycle, WIDTH cycles in MUL; result = low WIDTH bits of product; overflow = 1 iff high WIDTH bits nonzero; carry=0; out_valid set on the edge leaving MUL (latency WIDTH+1).
REQ-023 zero = (result == 0) for every op, registered with result.
REQ-024 Result held stable while out_valid & !out_ready; cleared out_valid on consume unless a new accept lands same edge.
REQ-025 Consume and accept same cycle: new result replaces old, out_valid stays 1.
REQ-026 in_valid during MUL ignored (in_ready=0); busy=1 exactly while state==MUL.

Reset
REQ-027 rst_n low asynchronously forces state=IDLE, out_valid=0, busy=0, result=0, overflow=0, carry=0, zero=0, iteration counter=0.
REQ-028 Reset mid-MUL aborts; no result emitted; first accept after deassert starts fresh.
REQ-029 in_ready=1 on the first edge after rst_n deasserts.

Configuration
REQ-030 Macro SEQ_ALU_MUL_EN: defined -> MUL state, counter and product register present per REQ-022.
REQ-031 Macro SEQ_ALU_MUL_EN undefined -> no MUL hardware; opcode 111 completes at latency 1 with result=0, zero=1, overflow=0, carry=0; busy tied 0.

Verification
REQ-032 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow 1, carry 0, zero 0, one cycle after accept.
REQ-033 ADD a=0xFFFFFFFF b=1 -> result 0, carry 1, overflow 0, zero 1; SUB a=0x80000000 b=1 -> 0x7FFFFFFF, overflow 1, carry 1.
REQ-034 SLT a=0xFFFFFFFB b=10 -> 1; SLTU same operands -> 0; SLT a=b=10 -> 0, zero 1.
REQ-035 MUL (macro on) a=0x10000 b=0x10000 -> result 0, overflow 1, out_valid 33 cycles after accept, busy 32 cycles, in_ready 0 throughout; a=6 b=7 -> 42, overflow 0.
REQ-036 Backpressure: three ADDs streamed with out_ready=0 -> first result held, in_ready 0 until out_ready=1; then results 1:1 with no loss or duplication.
REQ-037 rst_n pulsed low mid-MUL -> out_valid 0, busy 0 immediately; next ADD 10+5 -> 15.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ADD/SUB/AND/XOR/OR/SLT/SLTU; MUL is an optional unsigned
// shift-add multiplier taking WIDTH cycles, enabled by defining the
// macro SEQ_ALU_MUL_EN. With the macro undefined, opcode 111 completes in
// one cycle with result 0 and busy is tied low.
module seq_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             carry,
   output logic             zero,
   output logic             busy
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_XOR  = 3'b011,
      OP_OR   = 3'b100,
      OP_SLT  = 3'b101,
      OP_SLTU = 3'b110,
      OP_MUL  = 3'b111
   } op_e;

   op_e              w_op;
   logic             w_accept;
   logic             w_accept_alu;
   logic             w_is_mul;
   logic             w_idle;
   logic             w_mul_done;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_ov;
   logic             w_alu_cy;
   logic [2*WIDTH-1:0] w_prod_next;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_overflow;
   logic             r_carry;
   logic             r_zero;

   assign w_op         = op_e'(alu_control);
   assign in_ready     = w_idle & (~r_out_valid | out_ready);
   assign w_accept     = in_valid & in_ready;
   assign w_accept_alu = w_accept & ~w_is_mul;

   // Carry-out of both adders is bit WIDTH; SUB carry=1 means no borrow.
   assign w_add = {1'b0, a} + {1'b0, b};
   assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

   localparam int CW = $clog2(WIDTH);

   state_e             r_state;
   state_e             w_state_next;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   // Upper half accumulates partial sums, lower half holds the remaining
   // multiplier bits; the whole register shifts right once per iteration.
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH:0]     w_partial;

   assign w_is_mul    = (w_op == OP_MUL);
   assign w_idle      = (r_state == S_IDLE);
   assign busy        = (r_state == S_MUL);
   assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
   assign w_partial   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                      + (r_prod[0] ? {1'b0, r_mcand} : '0);
   assign w_prod_next = {w_partial, r_prod[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state: start on an accepted MUL, return after WIDTH iterations.
   always_comb begin
      // NOTE: default first so every path assigns it and no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
         S_MUL:   if (w_mul_done)          w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Multiplier datapath: load operands on accept, one add-shift per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_mcand <= '0;
         r_prod  <= '0;
      end else if (w_accept && w_is_mul) begin
         r_cnt   <= '0;
         r_mcand <= a;
         r_prod  <= {{WIDTH{1'b0}}, b};
      end else if (r_state == S_MUL) begin
         r_prod  <= w_prod_next;
         r_cnt   <= w_mul_done ? '0 : r_cnt + 1'b1;
      end
   end
`else
   assign w_is_mul    = 1'b0;
   assign w_idle      = 1'b1;
   assign busy        = 1'b0;
   assign w_mul_done  = 1'b0;
   assign w_prod_next = '0;
`endif

   // Single-cycle operations; opcode 111 falls to the default when it
   // does not reach the multiplier.
   always_comb begin
      w_alu_res = '0;
      w_alu_ov  = 1'b0;
      w_alu_cy  = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_alu_res = w_add[WIDTH-1:0];
            w_alu_cy  = w_add[WIDTH];
            w_alu_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_sub[WIDTH-1:0];
            w_alu_cy  = w_sub[WIDTH];
            w_alu_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  w_alu_res = a & b;
         OP_XOR:  w_alu_res = a ^ b;
         OP_OR:   w_alu_res = a | b;
         // Direct signed compare, so a-b overflow cannot corrupt the answer.
         OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: w_alu_res = '0;
      endcase
   end

   // Output register: load on ALU accept or MUL completion, hold under
   // backpressure, drop valid when consumed with nothing new arriving.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: result/flags are reset because their reset value is visible
      // on the ports; the operand registers above are reset for symmetry.
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_overflow  <= 1'b0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_mul_done) begin
         r_out_valid <= 1'b1;
         r_result    <= w_prod_next[WIDTH-1:0];
         r_overflow  <= |w_prod_next[2*WIDTH-1:WIDTH];
         r_carry     <= 1'b0;
         r_zero      <= ~|w_prod_next[WIDTH-1:0];
      end else if (w_accept_alu) begin
         r_out_valid <= 1'b1;
         r_result    <= w_alu_res;
         r_overflow  <= w_alu_ov;
         r_carry     <= w_alu_cy;
         r_zero      <= ~|w_alu_res;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign overflow  = r_overflow;
   assign carry     = r_carry;
   assign zero      = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed corner cases plus randomized streams for seq_alu,
// scored against an arithmetic reference model. MUL expectations follow
// SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;

   localparam int WIDTH = 32;
`ifdef SEQ_ALU_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] res;
      logic        ov;
      logic        cy;
      logic        z;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       alu_control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             carry;
   logic             zero;
   logic             busy;

   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .overflow    (overflow),
      .carry       (carry),
      .zero        (zero),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case some wait is never satisfied.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference model: exact integer arithmetic, then truncate.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      longint sx, sy, s;
      longint unsigned ux, uy, p;
      sx = longint'(int'(x));
      sy = longint'(int'(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      e  = '0;
      case (op)
         3'd0: begin
            p     = ux + uy;
            e.res = p[31:0];
            e.cy  = p[32];
            s     = sx + sy;
            e.ov  = (s != longint'(int'(e.res)));
         end
         3'd1: begin
            e.res = x - y;
            e.cy  = (ux >= uy);
            s     = sx - sy;
            e.ov  = (s != longint'(int'(e.res)));
         end
         3'd2: e.res = x & y;
         3'd3: e.res = x ^ y;
         3'd4: e.res = x | y;
         3'd5: e.res = (sx < sy) ? 32'd1 : 32'd0;
         3'd6: e.res = (ux < uy) ? 32'd1 : 32'd0;
         default: begin
            if (MUL_ON) begin
               p     = ux * uy;
               e.res = p[31:0];
               e.ov  = (p[63:32] != 32'd0);
            end
         end
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] corners [5];
      corners[0] = 32'h0000_0000;
      corners[1] = 32'h0000_0001;
      corners[2] = 32'h7FFF_FFFF;
      corners[3] = 32'h8000_0000;
      corners[4] = 32'hFFFF_FFFF;
      if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
      return $urandom();
   endfunction

   // One operation with out_ready high: checks latency, busy length,
   // in_ready during iteration, and the registered result/flags.
   task automatic single_op(input string tag, input logic [2:0] op,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] er, input logic eov, input logic ecy,
                            input logic ez, input int elat);
      int lat;
      int busy_cnt;
      bit done;
      @(negedge clk);
      a = x; b = y; alu_control = op; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({tag, "_idle_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
      // Keep offering junk: it must not disturb the operation in flight.
      a = $urandom(); b = $urandom(); alu_control = 3'd0;
      lat = 0; busy_cnt = 0; done = 1'b0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
         if (busy) begin
            busy_cnt++;
            check({tag, "_in_ready_busy"}, in_ready, 0);
         end
         if (out_valid) begin
            done = 1'b1;
            in_valid = 1'b0;
         end
      end
      check({tag, "_latency"}, lat, elat);
      check({tag, "_busy_cycles"}, busy_cnt, elat - 1);
      check({tag, "_result"}, result, er);
      check({tag, "_overflow"}, overflow, eov);
      check({tag, "_carry"}, carry, ecy);
      check({tag, "_zero"}, zero, ez);
      @(negedge clk);
      #1;
      check({tag, "_consumed"}, out_valid, 0);
   endtask

   // Randomized traffic with random valid/ready; accepted ops are queued
   // as expected results and compared while they sit on the output.
   task automatic run_stream(input string tag, input int n, input int valid_pct, input int ready_pct);
      exp_t        q[$];
      int          sent, got, cycles;
      bit          pending, fire_in, fire_out;
      logic [2:0]  p_op;
      logic [31:0] p_a, p_b;
      sent = 0; got = 0; cycles = 0; pending = 1'b0;
      p_op = '0; p_a = '0; p_b = '0;
      while (got < n && cycles < n * 60 + 200) begin
         @(negedge clk);
         if (!pending && sent < n) begin
            p_op = 3'($urandom_range(7));
            p_a = pick_operand();
            p_b = pick_operand();
            pending = 1'b1;
         end
         a = p_a; b = p_b; alu_control = p_op;
         in_valid  = pending && ($urandom_range(99) < valid_pct);
         out_ready = ($urandom_range(99) < ready_pct);
         #1;
         if (out_valid) begin
            if (q.size() == 0) begin
               check({tag, "_spurious_out_valid"}, out_valid, 0);
            end else begin
               check({tag, "_result"}, result, q[0].res);
               check({tag, "_overflow"}, overflow, q[0].ov);
               check({tag, "_carry"}, carry, q[0].cy);
               check({tag, "_zero"}, zero, q[0].z);
            end
            if (!out_ready) check({tag, "_in_ready_stalled"}, in_ready, 0);
         end
         if (busy) check({tag, "_in_ready_busy"}, in_ready, 0);
         fire_out = out_valid && out_ready && (q.size() != 0);
         fire_in  = in_valid && in_ready;
         @(posedge clk);
         if (fire_out) begin
            void'(q.pop_front());
            got++;
         end
         if (fire_in) begin
            q.push_back(model(p_op, p_a, p_b));
            sent++;
            pending = 1'b0;
         end
         cycles++;
      end
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check({tag, "_all_results_seen"}, got, n);
      @(negedge clk);
      #1;
      check({tag, "_drained"}, out_valid, 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; alu_control = '0;
      #2;
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_result", result, 0);
      check("reset_flags", {overflow, carry, zero}, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset_in_ready", in_ready, 1);

      // Arithmetic and compare corners.
      single_op("add_sovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0, 0, 1);
      single_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1, 1, 1);
      single_op("sub_sovf", 3'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 1, 0, 1);
      single_op("sub_borrow", 3'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, 0, 0, 1);
      single_op("and", 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 1);
      single_op("xor", 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0, 1);
      single_op("or",  3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 1);
      single_op("slt_neg", 3'd5, 32'hFFFF_FFFB, 32'd10, 32'd1, 0, 0, 0, 1);
      single_op("sltu_neg", 3'd6, 32'hFFFF_FFFB, 32'd10, 32'd0, 0, 0, 1, 1);
      single_op("slt_eq", 3'd5, 32'd10, 32'd10, 32'd0, 0, 0, 1, 1);
      single_op("slt_ovf", 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 1);

      if (MUL_ON) begin
         single_op("mul_hi", 3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 0, 1, WIDTH + 1);
         single_op("mul_small", 3'd7, 32'd6, 32'd7, 32'd42, 0, 0, 0, WIDTH + 1);
         single_op("mul_max", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, WIDTH + 1);
      end else begin
         single_op("mul_off", 3'd7, 32'd6, 32'd7, 32'd0, 0, 0, 1, 1);
      end

      // Backpressure: three ADDs streamed while the consumer stalls.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; alu_control = 3'd0; a = 32'd1; b = 32'd2;
      #1;
      check("bp_first_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      a = 32'd3; b = 32'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_result", result, 32'd3);
         check("bp_hold_in_ready", in_ready, 0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      a = 32'd5; b = 32'd6;
      @(negedge clk);
      #1;
      check("bp_second_valid", out_valid, 1);
      check("bp_second_result", result, 32'd7);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("bp_third_valid", out_valid, 1);
      check("bp_third_result", result, 32'd11);
      @(negedge clk);
      #1;
      check("bp_drained", out_valid, 0);

      // Reset in the middle of work: nothing may come out afterwards.
      @(negedge clk);
      in_valid = 1'b1; a = 32'd123; b = 32'd456;
      alu_control = MUL_ON ? 3'd7 : 3'd0;
      out_ready = MUL_ON ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      if (MUL_ON) check("rst_pre_busy", busy, 1);
      else        check("rst_pre_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_result", result, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rst_release_in_ready", in_ready, 1);
      repeat (WIDTH + 4) @(negedge clk);
      #1;
      check("rst_no_stale_result", out_valid, 0);
      single_op("rst_add", 3'd0, 32'd10, 32'd5, 32'd15, 0, 0, 0, 1);

      // Randomized traffic: stalls on both sides, then full rate.
      run_stream("rand_mixed", 120, 70, 60);
      run_stream("rand_full", 120, 100, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
